// File: rtl/spi_slave.sv
// SPI responder: oversamples sck/ss_n/mosi on clk, deserialises mosi into rx_data and
// shifts a one-deep buffered tx word out on miso, MSB first, in any CPOL/CPHA mode.
module spi_slave #(
    parameter int   DATA_WIDTH = 8,
    parameter logic CPOL       = 1'b0,
    parameter logic CPHA       = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sck,
    input  logic                  ss_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_wr,
    output logic                  tx_ready,
    output logic                  tx_underrun,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ack,
    output logic                  rx_overrun
);
    localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state;

    // _p0/_p1 are the two synchroniser flops, _p2 is the edge-detect history
    logic sck_p0, sck_p1, sck_p2;
    logic ss_p0, ss_p1, ss_p2;
    logic mosi_p0, mosi_p1;

    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-2:0] rx_shift;
    logic [DATA_WIDTH-1:0] rx_word;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-1:0] tx_hold;
    logic lead_edge, trail_edge, sample_edge, shift_edge;
    logic ss_fall, ss_rise, deselect, load, word_done;

    always_comb begin
        lead_edge   = (sck_p1 != CPOL) && (sck_p2 == CPOL);
        trail_edge  = (sck_p1 == CPOL) && (sck_p2 != CPOL);
        ss_fall     = ss_p2 && !ss_p1;
        ss_rise     = !ss_p2 && ss_p1;
        deselect    = (state == ACTIVE) && ss_rise;
        sample_edge = (state == ACTIVE) && !ss_rise && (CPHA ? trail_edge : lead_edge);
        shift_edge  = (state == ACTIVE) && !ss_rise && (CPHA ? lead_edge : trail_edge);
        // With CPHA=0 the first bit must be on miso before the first sck edge
        load        = (shift_edge && (bit_cnt == '0)) ||
                      (!CPHA && (state == IDLE) && ss_fall);
        rx_word     = {rx_shift, mosi_p1};
        word_done   = sample_edge && (bit_cnt == LAST_BIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_p0      <= CPOL;
            sck_p1      <= CPOL;
            sck_p2      <= CPOL;
            ss_p0       <= 1'b1;
            ss_p1       <= 1'b1;
            ss_p2       <= 1'b1;
            mosi_p0     <= 1'b0;
            mosi_p1     <= 1'b0;
            state       <= IDLE;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            tx_hold     <= '0;
            tx_ready    <= 1'b1;
            tx_underrun <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            rx_overrun  <= 1'b0;
        end else begin
            sck_p0  <= sck;
            sck_p1  <= sck_p0;
            sck_p2  <= sck_p1;
            ss_p0   <= ss_n;
            ss_p1   <= ss_p0;
            ss_p2   <= ss_p1;
            mosi_p0 <= mosi;
            mosi_p1 <= mosi_p0;

            if ((state == IDLE) && ss_fall)
                state <= ACTIVE;
            else if (deselect)
                state <= IDLE;

            tx_underrun <= load && tx_ready;
            rx_overrun  <= word_done && rx_valid && !rx_ack;

            // A write landing with an underrun load is kept for the next load
            if (load && !tx_ready)
                tx_ready <= 1'b1;
            else if (tx_wr && tx_ready) begin
                tx_hold  <= tx_data;
                tx_ready <= 1'b0;
            end

            if (deselect)
                tx_shift <= '0;
            else if (load)
                tx_shift <= tx_ready ? '0 : tx_hold;
            else if (shift_edge)
                tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};

            if (deselect) begin
                bit_cnt  <= '0;
                rx_shift <= '0;
            end else if (sample_edge) begin
                rx_shift <= rx_word[DATA_WIDTH-2:0];
                bit_cnt  <= word_done ? '0 : bit_cnt + CNT_W'(1);
            end

            // A completing word beats a simultaneous acknowledge
            if (word_done) begin
                rx_data  <= rx_word;
                rx_valid <= 1'b1;
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign miso    = tx_shift[DATA_WIDTH-1];
    assign miso_oe = !ss_p1;
endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a mode-0 and a mode-3 instance share one bus-functional master,
// selected by m3; single-word vectors from a table plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_spi_slave;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic m3 = 1'b0;
    logic sck = 1'b0;
    logic ss_n = 1'b1;
    logic mosi = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic tx_wr = 1'b0;
    logic rx_ack = 1'b0;

    logic sck0, ss0, wr0, ack0, sck3, ss3, wr3, ack3;
    logic miso0, oe0, rdy0, urun0, rv0, orun0;
    logic miso3, oe3, rdy3, urun3, rv3_o, orun3;
    logic [7:0] rxd0, rxd3;
    logic miso, miso_oe, tx_ready, tx_underrun, rx_valid, rx_overrun;
    logic [7:0] rx_data;

    assign sck0 = m3 ? 1'b0 : sck;
    assign ss0  = m3 ? 1'b1 : ss_n;
    assign wr0  = m3 ? 1'b0 : tx_wr;
    assign ack0 = m3 ? 1'b0 : rx_ack;
    assign sck3 = m3 ? sck : 1'b1;
    assign ss3  = m3 ? ss_n : 1'b1;
    assign wr3  = m3 ? tx_wr : 1'b0;
    assign ack3 = m3 ? rx_ack : 1'b0;

    assign miso        = m3 ? miso3 : miso0;
    assign miso_oe     = m3 ? oe3 : oe0;
    assign tx_ready    = m3 ? rdy3 : rdy0;
    assign tx_underrun = m3 ? urun3 : urun0;
    assign rx_data     = m3 ? rxd3 : rxd0;
    assign rx_valid    = m3 ? rv3_o : rv0;
    assign rx_overrun  = m3 ? orun3 : orun0;

    spi_slave #(.DATA_WIDTH(8), .CPOL(1'b0), .CPHA(1'b0)) u_mode0 (
        .clk(clk), .rst(rst), .sck(sck0), .ss_n(ss0), .mosi(mosi),
        .miso(miso0), .miso_oe(oe0), .tx_data(tx_data), .tx_wr(wr0),
        .tx_ready(rdy0), .tx_underrun(urun0), .rx_data(rxd0), .rx_valid(rv0),
        .rx_ack(ack0), .rx_overrun(orun0));

    spi_slave #(.DATA_WIDTH(8), .CPOL(1'b1), .CPHA(1'b1)) u_mode3 (
        .clk(clk), .rst(rst), .sck(sck3), .ss_n(ss3), .mosi(mosi),
        .miso(miso3), .miso_oe(oe3), .tx_data(tx_data), .tx_wr(wr3),
        .tx_ready(rdy3), .tx_underrun(urun3), .rx_data(rxd3), .rx_valid(rv3_o),
        .rx_ack(ack3), .rx_overrun(orun3));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int urun_cnt = 0;
    int orun_cnt = 0;
    always @(posedge clk) begin
        if (tx_underrun) urun_cnt <= urun_cnt + 1;
        if (rx_overrun)  orun_cnt <= orun_cnt + 1;
    end

    // miso in mode 3 may only move shortly after a falling sck
    logic mon_en = 1'b0;
    logic sck_q = 1'b1;
    logic miso_q = 1'b0;
    int since_fall = 100;
    int mon_bad = 0;
    always @(posedge clk) begin
        sck_q      <= sck;
        miso_q     <= miso;
        since_fall <= (sck_q && !sck) ? 0 : since_fall + 1;
        if (mon_en && (miso !== miso_q) && (since_fall > 4)) mon_bad <= mon_bad + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    logic rv_n2, rv_n3;
    task automatic hold_after_sample();
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 2) rv_n2 = rx_valid;
            if (k == 3) rv_n3 = rx_valid;
        end
    endtask

    // Master: half period 4 clk; mode 0 samples on rise, mode 3 on the trailing rise
    task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int b = 7; b > 7 - nbits; b--) begin
            if (!m3) begin
                mosi = mo[b];
                repeat (4) @(negedge clk);
                mi[b] = miso;
                sck = 1'b1;
                hold_after_sample();
                sck = 1'b0;
            end else begin
                sck = 1'b0;
                mosi = mo[b];
                repeat (4) @(negedge clk);
                mi[b] = miso;
                sck = 1'b1;
                hold_after_sample();
            end
        end
    endtask

    task automatic set_mode(input logic v);
        m3 = v;
        sck = v;
        ss_n = 1'b1;
        mosi = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic start_frame();
        ss_n = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic end_frame();
        repeat (4) @(negedge clk);
        ss_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic write_tx(input logic [7:0] v);
        tx_data = v;
        tx_wr = 1'b1;
        @(negedge clk);
        tx_wr = 1'b0;
    endtask

    task automatic ack_rx();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
    endtask

    typedef struct {
        logic       m3;
        logic [7:0] tx;
        logic [7:0] mo;
        logic [7:0] exp_rx;
        logic [7:0] exp_mi;
    } vec_t;
    vec_t vecs[5];

    logic [7:0] mi, mi1, mi2;
    logic [7:0] rxq[2];
    int u0, o0, na, nb;

    initial begin
        vecs[0] = '{1'b0, 8'h3C, 8'hA5, 8'hA5, 8'h3C};
        vecs[1] = '{1'b1, 8'h81, 8'h7E, 8'h7E, 8'h81};
        vecs[2] = '{1'b0, 8'hFF, 8'h00, 8'h00, 8'hFF};
        vecs[3] = '{1'b1, 8'h00, 8'hFF, 8'hFF, 8'h00};
        vecs[4] = '{1'b1, 8'hC9, 8'h36, 8'h36, 8'hC9};

        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_miso", miso, 0);
        check("rst_miso_oe", miso_oe, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_tx_underrun", tx_underrun, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_overrun", rx_overrun, 0);

        // single-word frames from the table
        for (int i = 0; i < 5; i++) begin
            set_mode(vecs[i].m3);
            write_tx(vecs[i].tx);
            check("vec_tx_ready_after_wr", tx_ready, 0);
            start_frame();
            check("vec_miso_oe", miso_oe, 1);
            check("vec_tx_ready_after_ss", tx_ready, vecs[i].m3 ? 1'b0 : 1'b1);
            mon_en = vecs[i].m3;
            xfer(vecs[i].mo, 8, mi);
            mon_en = 1'b0;
            check("vec_rv_before_latency", rv_n2, 0);
            check("vec_rv_after_latency", rv_n3, 1);
            end_frame();
            check("vec_rx_data", rx_data, vecs[i].exp_rx);
            check("vec_rx_valid", rx_valid, 1);
            check("vec_master_rx", mi, vecs[i].exp_mi);
            ack_rx();
            check("vec_rx_ack_clears", rx_valid, 0);
        end
        check("mode3_miso_only_after_fall", mon_bad, 0);

        // back-to-back words in one frame, mode 3
        set_mode(1'b1);
        write_tx(8'h11);
        u0 = urun_cnt;
        o0 = orun_cnt;
        start_frame();
        fork
            begin
                xfer(8'hAA, 8, mi1);
                xfer(8'h55, 8, mi2);
            end
            begin
                na = 0;
                while (!tx_ready && na < 400) begin @(negedge clk); na++; end
                check("b2b_tx_ready_rise", tx_ready, 1);
                write_tx(8'h22);
            end
            begin
                for (int k = 0; k < 2; k++) begin
                    nb = 0;
                    while (!rx_valid && nb < 400) begin @(negedge clk); nb++; end
                    check("b2b_rx_valid", rx_valid, 1);
                    rxq[k] = rx_data;
                    ack_rx();
                end
            end
        join
        end_frame();
        check("b2b_rx0", rxq[0], 8'hAA);
        check("b2b_rx1", rxq[1], 8'h55);
        check("b2b_master0", mi1, 8'h11);
        check("b2b_master1", mi2, 8'h22);
        check("b2b_underruns", urun_cnt - u0, 0);
        check("b2b_overruns", orun_cnt - o0, 0);

        // no tx writes, no acks across two words, mode 3
        u0 = urun_cnt;
        o0 = orun_cnt;
        start_frame();
        xfer(8'h01, 8, mi1);
        xfer(8'h02, 8, mi2);
        end_frame();
        check("ovr_master0", mi1, 8'h00);
        check("ovr_master1", mi2, 8'h00);
        check("ovr_underruns", urun_cnt - u0, 2);
        check("ovr_overruns", orun_cnt - o0, 1);
        check("ovr_rx_data", rx_data, 8'h02);
        check("ovr_rx_valid", rx_valid, 1);
        ack_rx();

        // sck activity while deselected, then an aborted frame, mode 0
        set_mode(1'b0);
        for (int k = 0; k < 6; k++) begin
            sck = ~sck;
            repeat (4) @(negedge clk);
        end
        check("idle_sck_no_valid", rx_valid, 0);
        start_frame();
        xfer(8'hF0, 4, mi);
        repeat (4) @(negedge clk);
        ss_n = 1'b1;
        @(negedge clk);
        check("abort_oe_before_detect", miso_oe, 1);
        @(negedge clk);
        check("abort_oe_at_detect", miso_oe, 0);
        repeat (8) @(negedge clk);
        check("abort_no_valid", rx_valid, 0);
        start_frame();
        xfer(8'hC3, 8, mi);
        end_frame();
        check("abort_next_rx_data", rx_data, 8'hC3);
        check("abort_next_rx_valid", rx_valid, 1);
        ack_rx();

        // reset in the middle of a word, mode 0
        write_tx(8'hE7);
        start_frame();
        write_tx(8'h99);
        check("midrst_hold_full", tx_ready, 0);
        xfer(8'hFF, 2, mi);
        check("midrst_miso_before", miso, 1);
        rst = 1'b1;
        #1;
        check("midrst_miso", miso, 0);
        check("midrst_miso_oe", miso_oe, 0);
        check("midrst_tx_ready", tx_ready, 1);
        check("midrst_tx_underrun", tx_underrun, 0);
        check("midrst_rx_data", rx_data, 0);
        check("midrst_rx_valid", rx_valid, 0);
        check("midrst_rx_overrun", rx_overrun, 0);
        ss_n = 1'b1;
        sck = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        write_tx(8'h5A);
        start_frame();
        xfer(8'h96, 8, mi);
        end_frame();
        check("postrst_rx_data", rx_data, 8'h96);
        check("postrst_rx_valid", rx_valid, 1);
        check("postrst_master", mi, 8'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
